uart_tx: RTL and testbench

- Serial UART transmitter on the outbound side of the host link.
- Accepts one byte per strobe from the message buffer (txdata/send) and shifts it out on tx as 8N1 by default, optionally with parity or 2 stop bits.
- Signals frame completion back to the buffer with a one-cycle txdone pulse.
- Sits between the message buffer's tx byte interface and the board TX pin.

---
 rtl/uart_tx.sv | 137 +++++++++++++
 tb/tb_uart_tx.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter, one byte per send strobe.
// Frame: start bit (0), 8 data bits LSB first, optional parity bit,
// STOP_BITS stop bits (1). Each bit lasts CLKS_PER_BIT clocks.
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   txdata - byte to send, sampled only on the accepting cycle
//   send   - start strobe, honoured only while idle
//   txdone - one-cycle pulse in the first idle cycle after a frame
//   busy   - high while a frame is on the line
//   tx     - serial output, idle high
// All outputs are registered. They are loaded from the next-state values,
// so they change on the same edge as the FSM.
module uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY       = 0,   // 0 none, 1 even, 2 odd
  parameter int STOP_BITS    = 1    // 1 or 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] txdata,
  input  logic       send,
  output logic       txdone,
  output logic       busy,
  output logic       tx
);

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]    bitc, bitc_n;
  logic [7:0]    shreg, shreg_n;
  logic          par, par_n;
  logic          tx_n, busy_n, txdone_n;
  logic          bit_end;

  assign bit_end = (baud == BW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_n  = state;
    baud_n   = baud + BW'(1);
    bitc_n   = bitc;
    shreg_n  = shreg;
    par_n    = par;
    txdone_n = 1'b0;
    unique case (state)
      S_IDLE: begin
        baud_n = '0;
        if (send) begin
          shreg_n = txdata;
          // Even parity is the XOR of the data bits; odd parity inverts it.
          par_n   = (^txdata) ^ (PARITY == 2);
          bitc_n  = '0;
          state_n = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          baud_n  = '0;
          state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_n  = '0;
          shreg_n = shreg >> 1;
          if (bitc == 3'd7) begin
            bitc_n  = '0;
            state_n = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bitc_n = bitc + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          baud_n  = '0;
          state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          baud_n = '0;
          if (bitc == 3'(STOP_BITS - 1)) begin
            bitc_n   = '0;
            txdone_n = 1'b1;
            state_n  = S_IDLE;
          end else begin
            bitc_n = bitc + 3'd1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Line value for the state being entered.
    unique case (state_n)
      S_START:  tx_n = 1'b0;
      S_DATA:   tx_n = shreg_n[0];
      S_PARITY: tx_n = par_n;
      default:  tx_n = 1'b1;
    endcase
    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      baud   <= '0;
      bitc   <= '0;
      shreg  <= '0;
      par    <= 1'b0;
      tx     <= 1'b1;
      busy   <= 1'b0;
      txdone <= 1'b0;
    end else begin
      state  <= state_n;
      baud   <= baud_n;
      bitc   <= bitc_n;
      shreg  <= shreg_n;
      par    <= par_n;
      tx     <= tx_n;
      busy   <= busy_n;
      txdone <= txdone_n;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances with CLKS_PER_BIT=4 share the inputs
// (u0: 8N1, u1: even parity, u2: odd parity, u3: two stop bits). Expected
// line values come from a frame model built as a bit list from the byte.
module tb_uart_tx;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] txdata = 8'h00;
  logic       send = 1'b0;
  logic [3:0] tx_v, busy_v, done_v;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .txdata(txdata), .send(send),
    .txdone(done_v[0]), .busy(busy_v[0]), .tx(tx_v[0]));
  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .txdata(txdata), .send(send),
    .txdone(done_v[1]), .busy(busy_v[1]), .tx(tx_v[1]));
  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) u2 (
    .clk(clk), .rst_n(rst_n), .txdata(txdata), .send(send),
    .txdone(done_v[2]), .busy(busy_v[2]), .tx(tx_v[2]));
  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(2)) u3 (
    .clk(clk), .rst_n(rst_n), .txdata(txdata), .send(send),
    .txdone(done_v[3]), .busy(busy_v[3]), .tx(tx_v[3]));

  function automatic int par_of(input int i);
    return (i == 1) ? 1 : (i == 2) ? 2 : 0;
  endfunction

  function automatic int stb_of(input int i);
    return (i == 3) ? 2 : 1;
  endfunction

  function automatic int flen(input int i);
    return CPB * (9 + ((par_of(i) != 0) ? 1 : 0) + stb_of(i));
  endfunction

  // Line value in cycle t (t=1 is the first cycle after the accepting edge).
  function automatic logic model_tx(input logic [7:0] b, input int i, input int t);
    int idx;
    if (t < 1 || t > flen(i)) return 1'b1;
    idx = (t - 1) / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (par_of(i) != 0 && idx == 9) return (^b) ^ (par_of(i) == 2);
    return 1'b1;
  endfunction

  task automatic strobe(input logic [7:0] b);
    @(negedge clk);
    txdata = b;
    send = 1'b1;
    @(posedge clk);
    #1 send = 1'b0;
  endtask

  task automatic check_idle(input string nm, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      checks++;
      if (tx_v !== 4'hF || busy_v !== 4'h0 || done_v !== 4'h0) begin
        failures++;
        $display("FAIL %s: tx=%b busy=%b done=%b, need tx=1111 busy=0000 done=0000",
                 nm, tx_v, busy_v, done_v);
      end
    end
  endtask

  // Watch one frame already accepted. mask picks instances to check,
  // inject strobes send with txdata=0 mid-frame, chain strobes nxt in
  // u0's txdone cycle. dec returns the byte decoded from u0 at mid-bit.
  task automatic watch(input string nm, input logic [7:0] b, input logic [3:0] mask,
                       input bit inject, input bit chain, input logic [7:0] nxt,
                       output logic [7:0] dec);
    int tmax;
    dec = 8'h00;
    tmax = chain ? flen(0) + 1 : flen(3) + 2;
    for (int t = 1; t <= tmax; t++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) begin
          checks++;
          if (tx_v[i] !== model_tx(b, i, t) || busy_v[i] !== (t <= flen(i)) ||
              done_v[i] !== (t == flen(i) + 1)) begin
            failures++;
            $display("FAIL %s u%0d t=%0d byte=%h: tx=%b busy=%b done=%b, need tx=%b busy=%b done=%b",
                     nm, i, t, b, tx_v[i], busy_v[i], done_v[i],
                     model_tx(b, i, t), (t <= flen(i)), (t == flen(i) + 1));
          end
        end
      end
      if ((t - 1) % CPB == CPB / 2 && (t - 1) / CPB >= 1 && (t - 1) / CPB <= 8)
        dec[(t - 1) / CPB - 1] = tx_v[0];
      if (inject && t == 15) begin
        txdata = 8'h00;
        send = 1'b1;
        @(posedge clk);
        #1 send = 1'b0;
      end
    end
    if (chain) begin
      txdata = nxt;
      send = 1'b1;
      @(posedge clk);
      #1 send = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst_n = 1'b0;
    send = 1'b1;
    txdata = 8'h5A;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (tx_v !== 4'hF || busy_v !== 4'h0 || done_v !== 4'h0) begin
        failures++;
        $display("FAIL reset_hold: tx=%b busy=%b done=%b, need 1111/0000/0000",
                 tx_v, busy_v, done_v);
      end
    end
    send = 1'b0;
    rst_n = 1'b1;
    check_idle("reset_release_idle", 5);
    d = 8'h00;
  endtask

  task automatic test_frames();
    logic [7:0] d;
    logic [7:0] b;
    logic [7:0] fixed [3];
    fixed[0] = 8'hA5; fixed[1] = 8'h01; fixed[2] = 8'hFF;
    for (int n = 0; n < 9; n++) begin
      b = (n < 3) ? fixed[n] : 8'($urandom);
      strobe(b);
      watch("frame", b, 4'hF, 1'b0, 1'b0, 8'h00, d);
      checks++;
      if (d !== b) begin
        failures++;
        $display("FAIL frame_decode: got %h, need %h", d, b);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d1, d2;
    strobe(8'h3C);
    watch("busy_ignore", 8'h3C, 4'hF, 1'b1, 1'b1, 8'hC3, d1);
    watch("b2b_second", 8'hC3, 4'h1, 1'b0, 1'b0, 8'h00, d2);
    checks++;
    if (d1 !== 8'h3C || d2 !== 8'hC3) begin
      failures++;
      $display("FAIL b2b_decode: got %h %h, need 3c c3", d1, d2);
    end
    repeat (20) @(negedge clk);
    check_idle("b2b_settle", 3);
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    logic [7:0] b;
    b = 8'($urandom);
    strobe(8'hA5);
    repeat (18) @(negedge clk);   // cycle 18 lies in data bit 3
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx_v !== 4'hF || busy_v !== 4'h0 || done_v !== 4'h0) begin
      failures++;
      $display("FAIL reset_async: tx=%b busy=%b done=%b, need 1111/0000/0000",
               tx_v, busy_v, done_v);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_idle("reset_mid_after", 40);
    strobe(b);
    watch("post_reset", b, 4'hF, 1'b0, 1'b0, 8'h00, d);
    checks++;
    if (d !== b) begin
      failures++;
      $display("FAIL post_reset_decode: got %h, need %h", d, b);
    end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_back_to_back();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
